// File: rtl/biriscv_fetch_resp_buffer_if.sv
// Bus bundle for the fetch response buffer: fetch-side request port,
// icache request/response port and the buffered output stream.
// The slave modport is the buffer's view; master is the surrounding logic.
interface biriscv_fetch_resp_buffer_if;
  // fetch stage request
  logic        fe_rd_i;
  logic [31:0] fe_pc_i;
  logic [1:0]  fe_priv_i;
  logic        fe_accept_o;
  // icache request
  logic        ic_rd_o;
  logic [31:0] ic_pc_o;
  logic [1:0]  ic_priv_o;
  logic        ic_accept_i;
  // icache response
  logic        ic_valid_i;
  logic [63:0] ic_inst_i;
  logic        ic_error_i;
  logic        ic_page_fault_i;
  // buffered output stream
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_inst_o;
  logic [31:0] out_pc_o;
  logic        out_error_o;
  logic        out_page_fault_o;

  modport slave (
    input  fe_rd_i, fe_pc_i, fe_priv_i,
    output fe_accept_o,
    output ic_rd_o, ic_pc_o, ic_priv_o,
    input  ic_accept_i,
    input  ic_valid_i, ic_inst_i, ic_error_i, ic_page_fault_i,
    output out_valid_o, out_inst_o, out_pc_o, out_error_o, out_page_fault_o,
    input  out_ready_i
  );

  modport master (
    output fe_rd_i, fe_pc_i, fe_priv_i,
    input  fe_accept_o,
    input  ic_rd_o, ic_pc_o, ic_priv_o,
    output ic_accept_i,
    output ic_valid_i, ic_inst_i, ic_error_i, ic_page_fault_i,
    input  out_valid_o, out_inst_o, out_pc_o, out_error_o, out_page_fault_o,
    output out_ready_i
  );
endinterface

// File: rtl/biriscv_fetch_resp_buffer.sv
// Fetch response buffer: tracks outstanding icache reads, tags each with its
// PC and queues responses in a small FIFO. A flush empties the FIFO and turns
// every in-flight read into a stale one whose response is silently discarded.
// Credits (stale + live + buffered) never exceed DEPTH, so every live read
// always owns a FIFO slot and the FIFO cannot overflow.
module biriscv_fetch_resp_buffer #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  biriscv_fetch_resp_buffer_if.slave      bus,
  output logic                            protocol_err_o
);

  localparam int CNT_W = DEPTH_W + 1;
  // wide enough that the credit sum can never wrap, even if counters misbehave
  localparam int SUM_W = DEPTH_W + 3;

  // state
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   live_cnt_r;
  logic [CNT_W-1:0]   stale_cnt_r;
  logic [DEPTH_W-1:0] wr_ptr_r;
  logic [DEPTH_W-1:0] rd_ptr_r;
  logic [DEPTH_W-1:0] pcq_wr_r;
  logic [DEPTH_W-1:0] pcq_rd_r;
  logic               valid_r;
  logic               protocol_err_r;
  logic [31:0]        pcq_r     [DEPTH];
  logic [63:0]        inst_mem_r[DEPTH];
  logic [31:0]        pc_mem_r  [DEPTH];
  logic               err_mem_r [DEPTH];
  logic               pf_mem_r  [DEPTH];

  // combinational
  logic [SUM_W-1:0]   credit_sum_s;
  logic               credit_ok_s;
  logic               ic_rd_s;
  logic               issue_s;
  logic               resp_owed_s;
  logic               unsolicited_s;
  logic               push_s;
  logic               stale_drop_s;
  logic               pop_s;
  logic [CNT_W-1:0]   count_next_s;
  logic [CNT_W-1:0]   live_cnt_next_s;
  logic [CNT_W-1:0]   stale_cnt_next_s;

  // request side: issue only with a free credit and never during a flush
  always_comb begin
    credit_sum_s = SUM_W'(stale_cnt_r) + SUM_W'(live_cnt_r) + SUM_W'(count_r);
    credit_ok_s  = (credit_sum_s < SUM_W'(DEPTH));
    ic_rd_s      = bus.fe_rd_i & credit_ok_s & ~flush_i;
    issue_s      = ic_rd_s & bus.ic_accept_i;
  end

  assign bus.ic_rd_o     = ic_rd_s;
  assign bus.fe_accept_o = issue_s;
  assign bus.ic_pc_o     = bus.fe_pc_i;
  assign bus.ic_priv_o   = bus.fe_priv_i;

  // response classification: stale responses are owed first, then live ones
  always_comb begin
    resp_owed_s   = (stale_cnt_r != CNT_W'(0)) | (live_cnt_r != CNT_W'(0));
    unsolicited_s = bus.ic_valid_i & ~resp_owed_s;
    stale_drop_s  = bus.ic_valid_i & ~flush_i & (stale_cnt_r != CNT_W'(0));
    push_s        = bus.ic_valid_i & ~flush_i & (stale_cnt_r == CNT_W'(0)) &
                    (live_cnt_r != CNT_W'(0));
    pop_s         = valid_r & bus.out_ready_i & ~flush_i;
  end

  // next counter values; a flush converts live reads into stale ones
  always_comb begin
    count_next_s     = count_r;
    live_cnt_next_s  = live_cnt_r;
    stale_cnt_next_s = stale_cnt_r;
    if (flush_i) begin
      count_next_s     = CNT_W'(0);
      live_cnt_next_s  = CNT_W'(0);
      stale_cnt_next_s = stale_cnt_r + live_cnt_r -
                         CNT_W'(bus.ic_valid_i & resp_owed_s);
    end else begin
      count_next_s     = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      live_cnt_next_s  = live_cnt_r + CNT_W'(issue_s) - CNT_W'(push_s);
      stale_cnt_next_s = stale_cnt_r - CNT_W'(stale_drop_s);
    end
  end

  // counters, pointers, head-valid flag and sticky protocol error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r        <= '0;
      live_cnt_r     <= '0;
      stale_cnt_r    <= '0;
      wr_ptr_r       <= '0;
      rd_ptr_r       <= '0;
      pcq_wr_r       <= '0;
      pcq_rd_r       <= '0;
      valid_r        <= 1'b0;
      protocol_err_r <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      live_cnt_r  <= live_cnt_next_s;
      stale_cnt_r <= stale_cnt_next_s;
      valid_r     <= (count_next_s != CNT_W'(0));
      if (unsolicited_s) begin
        protocol_err_r <= 1'b1;
      end
      if (flush_i) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
        pcq_wr_r <= '0;
        pcq_rd_r <= '0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + DEPTH_W'(1);
          pcq_rd_r <= pcq_rd_r + DEPTH_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + DEPTH_W'(1);
        end
        if (issue_s) begin
          pcq_wr_r <= pcq_wr_r + DEPTH_W'(1);
        end
      end
    end
  end

  // storage: PC queue written on issue, response FIFO written on live response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcq_r[i]      <= 32'h0000_0000;
        inst_mem_r[i] <= 64'h0000_0000_0000_0000;
        pc_mem_r[i]   <= 32'h0000_0000;
        err_mem_r[i]  <= 1'b0;
        pf_mem_r[i]   <= 1'b0;
      end
    end else begin
      if (issue_s) begin
        pcq_r[pcq_wr_r] <= bus.fe_pc_i;
      end
      if (push_s) begin
        inst_mem_r[wr_ptr_r] <= bus.ic_inst_i;
        pc_mem_r[wr_ptr_r]   <= pcq_r[pcq_rd_r];
        err_mem_r[wr_ptr_r]  <= bus.ic_error_i;
        pf_mem_r[wr_ptr_r]   <= bus.ic_page_fault_i;
      end
    end
  end

  assign bus.out_valid_o      = valid_r;
  assign bus.out_inst_o       = inst_mem_r[rd_ptr_r];
  assign bus.out_pc_o         = pc_mem_r[rd_ptr_r];
  assign bus.out_error_o      = err_mem_r[rd_ptr_r];
  assign bus.out_page_fault_o = pf_mem_r[rd_ptr_r];
  assign protocol_err_o       = protocol_err_r;

  biriscv_fetch_resp_buffer_chk #(
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .valid_i     (valid_r),
    .count_i     (count_r),
    .live_cnt_i  (live_cnt_r),
    .stale_cnt_i (stale_cnt_r)
  );

endmodule

// Invariant checks for the fetch response buffer's credit accounting.
module biriscv_fetch_resp_buffer_chk #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input logic               clk_i,
  input logic               rst_ni,
  input logic               push_i,
  input logic               pop_i,
  input logic               valid_i,
  input logic [DEPTH_W:0]   count_i,
  input logic [DEPTH_W:0]   live_cnt_i,
  input logic [DEPTH_W:0]   stale_cnt_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && (count_i == (DEPTH_W+1)'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && (count_i == (DEPTH_W+1)'(0))));

  a_valid_matches_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    valid_i == (count_i != (DEPTH_W+1)'(0)));

  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((DEPTH_W+3)'(count_i) + (DEPTH_W+3)'(live_cnt_i) + (DEPTH_W+3)'(stale_cnt_i))
      <= (DEPTH_W+3)'(DEPTH));

endmodule

// File: tb/tb_biriscv_fetch_resp_buffer.sv
// Directed bench for biriscv_fetch_resp_buffer with hand-computed expectations.
module tb_biriscv_fetch_resp_buffer;

  logic clk;
  logic rst_n;
  logic flush;
  logic perr;
  int   total;
  int   bad;

  biriscv_fetch_resp_buffer_if bus ();

  biriscv_fetch_resp_buffer #(.DEPTH(4), .DEPTH_W(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .bus            (bus),
    .protocol_err_o (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic exp_acc, input string tag);
    bus.fe_rd_i = 1'b1;
    bus.fe_pc_i = pc;
    settle();
    check(tag, bus.fe_accept_o, exp_acc);
    tick();
    bus.fe_rd_i = 1'b0;
  endtask

  task automatic resp(input logic [63:0] inst, input logic err, input logic pf);
    bus.ic_valid_i      = 1'b1;
    bus.ic_inst_i       = inst;
    bus.ic_error_i      = err;
    bus.ic_page_fault_i = pf;
    tick();
    bus.ic_valid_i      = 1'b0;
    bus.ic_error_i      = 1'b0;
    bus.ic_page_fault_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.fe_rd_i         = 1'b0;
    bus.fe_pc_i         = 32'h0000_0000;
    bus.fe_priv_i       = 2'd0;
    bus.ic_accept_i     = 1'b1;
    bus.ic_valid_i      = 1'b0;
    bus.ic_inst_i       = 64'h0;
    bus.ic_error_i      = 1'b0;
    bus.ic_page_fault_i = 1'b0;
    bus.out_ready_i     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();

    // reset state
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_pc", bus.out_pc_o, 32'h0);
    check("rst_inst", bus.out_inst_o, 64'h0);
    check("rst_icrd", bus.ic_rd_o, 1'b0);

    // two reads, responses two and three cycles after the first issue
    bus.fe_rd_i   = 1'b1;
    bus.fe_pc_i   = 32'h0000_1000;
    bus.fe_priv_i = 2'd3;
    settle();
    check("a_icrd", bus.ic_rd_o, 1'b1);
    check("a_icpc", bus.ic_pc_o, 32'h0000_1000);
    check("a_priv", bus.ic_priv_o, 2'd3);
    check("a_acc0", bus.fe_accept_o, 1'b1);
    tick();
    issue(32'h0000_1008, 1'b1, "a_acc1");
    bus.out_ready_i = 1'b1;
    bus.ic_valid_i  = 1'b1;
    bus.ic_inst_i   = 64'h1111_2222_3333_4444;
    settle();
    check("a_nobypass", bus.out_valid_o, 1'b0);
    tick();
    check("a_v0", bus.out_valid_o, 1'b1);
    check("a_pc0", bus.out_pc_o, 32'h0000_1000);
    check("a_inst0", bus.out_inst_o, 64'h1111_2222_3333_4444);
    resp(64'h5555_6666_7777_8888, 1'b0, 1'b0);
    check("a_v1", bus.out_valid_o, 1'b1);
    check("a_pc1", bus.out_pc_o, 32'h0000_1008);
    check("a_inst1", bus.out_inst_o, 64'h5555_6666_7777_8888);
    tick();
    check("a_empty", bus.out_valid_o, 1'b0);

    // fill FIFO with consumer stalled; credits run out
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'h0000_1100 + 32'(i * 8), 1'b1, "b_acc");
    bus.fe_rd_i = 1'b1;
    settle();
    check("b_nocredit_live", bus.fe_accept_o, 1'b0);
    bus.fe_rd_i = 1'b0;
    for (int i = 0; i < 4; i++) resp(64'(i), 1'b0, 1'b0);
    bus.fe_rd_i = 1'b1;
    settle();
    check("b_full_noacc", bus.fe_accept_o, 1'b0);
    check("b_head0", bus.out_pc_o, 32'h0000_1100);
    bus.fe_rd_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    bus.fe_rd_i = 1'b1;
    settle();
    check("b_acc_after_pop", bus.fe_accept_o, 1'b1);
    check("b_head1", bus.out_pc_o, 32'h0000_1108);
    bus.fe_rd_i = 1'b0;
    tick();
    check("b_head2", bus.out_pc_o, 32'h0000_1110);
    tick();
    check("b_head3", bus.out_pc_o, 32'h0000_1118);
    check("b_inst3", bus.out_inst_o, 64'h3);
    tick();
    check("b_empty", bus.out_valid_o, 1'b0);

    // flush with three reads outstanding
    for (int i = 0; i < 3; i++) issue(32'h0000_1200 + 32'(i * 8), 1'b1, "c_acc");
    flush       = 1'b1;
    bus.fe_rd_i = 1'b1;
    settle();
    check("c_flush_nord", bus.ic_rd_o, 1'b0);
    tick();
    flush = 1'b0;
    issue(32'h0000_2000, 1'b1, "c_acc_2000");
    bus.fe_rd_i = 1'b1;
    bus.fe_pc_i = 32'h0000_2008;
    settle();
    check("c_stale_credit", bus.fe_accept_o, 1'b0);
    bus.fe_rd_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      resp(64'hdead_0000 + 64'(i), 1'b0, 1'b0);
      check("c_stale_drop", bus.out_valid_o, 1'b0);
    end
    resp(64'h2000_2000_2000_2000, 1'b0, 1'b0);
    check("c_v", bus.out_valid_o, 1'b1);
    check("c_pc", bus.out_pc_o, 32'h0000_2000);
    check("c_inst", bus.out_inst_o, 64'h2000_2000_2000_2000);
    tick();
    check("c_empty", bus.out_valid_o, 1'b0);

    // flush coincident with a live response: stale becomes 2-1 = 1
    issue(32'h0000_1300, 1'b1, "d_acc");
    issue(32'h0000_1308, 1'b1, "d_acc");
    flush = 1'b1;
    resp(64'hbad0, 1'b0, 1'b0);
    flush = 1'b0;
    check("d_flush_v", bus.out_valid_o, 1'b0);
    issue(32'h0000_1400, 1'b1, "d_acc");
    issue(32'h0000_1408, 1'b1, "d_acc");
    issue(32'h0000_1410, 1'b1, "d_acc");
    bus.fe_rd_i = 1'b1;
    settle();
    check("d_credit", bus.fe_accept_o, 1'b0);
    bus.fe_rd_i = 1'b0;
    resp(64'hbad1, 1'b0, 1'b0);
    check("d_stale_drop", bus.out_valid_o, 1'b0);
    resp(64'h1400, 1'b0, 1'b0);
    check("d_pc0", bus.out_pc_o, 32'h0000_1400);
    resp(64'h1408, 1'b0, 1'b0);
    check("d_pc1", bus.out_pc_o, 32'h0000_1408);
    resp(64'h1410, 1'b0, 1'b0);
    check("d_pc2", bus.out_pc_o, 32'h0000_1410);
    check("d_inst2", bus.out_inst_o, 64'h1410);
    tick();
    check("d_empty", bus.out_valid_o, 1'b0);

    // error and page-fault flags travel with their entries
    bus.out_ready_i = 1'b0;
    issue(32'h0000_3000, 1'b1, "e_acc");
    issue(32'h0000_3008, 1'b1, "e_acc");
    resp(64'h3000, 1'b1, 1'b0);
    resp(64'h3008, 1'b0, 1'b1);
    check("e_pc0", bus.out_pc_o, 32'h0000_3000);
    check("e_err0", bus.out_error_o, 1'b1);
    check("e_pf0", bus.out_page_fault_o, 1'b0);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("e_pc1", bus.out_pc_o, 32'h0000_3008);
    check("e_err1", bus.out_error_o, 1'b0);
    check("e_pf1", bus.out_page_fault_o, 1'b1);
    bus.out_ready_i = 1'b1;
    tick();
    check("e_empty", bus.out_valid_o, 1'b0);
    check("e_perr_clean", perr, 1'b0);

    // unsolicited response sets sticky protocol error
    resp(64'hffff, 1'b0, 1'b0);
    check("f_perr", perr, 1'b1);
    check("f_nodata", bus.out_valid_o, 1'b0);
    tick();
    tick();
    check("f_perr_sticky", perr, 1'b1);
    rst_n = 1'b0;
    settle();
    check("f_perr_rst", perr, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check("f_perr_after", perr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
